// File: rtl/jt12_acc_seq_pkg.sv
// jt12_acc_seq_pkg: shared state encoding, widths and operator-group map for the JT12 accumulator sequencer.
`default_nettype none

package jt12_acc_seq_pkg;

  localparam int CH_W  = 3;
  localparam int ALG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Enters vectors are {s4,s3,s2,s1}; chip order walks S1,S3,S2,S4.
  localparam logic [3:0] ENT_GRP0 = 4'b0001;
  localparam logic [3:0] ENT_GRP1 = 4'b0100;
  localparam logic [3:0] ENT_GRP2 = 4'b0010;
  localparam logic [3:0] ENT_GRP3 = 4'b1000;

  function automatic logic [3:0] group_enters(input logic [1:0] grp);
    case (grp)
      2'd0:    group_enters = ENT_GRP0;
      2'd1:    group_enters = ENT_GRP1;
      2'd2:    group_enters = ENT_GRP2;
      default: group_enters = ENT_GRP3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt12_acc_seq_cfg.sv
// jt12_acc_seq_cfg: per-channel rl/alg shadow file with a single-entry pending write buffer committed at round wraps.
// Optional macro JT12_ACC_SEQ_PCM_EN adds a shadowed pcm_req bit.
`default_nettype none

module jt12_acc_seq_cfg
  import jt12_acc_seq_pkg::*;
#(
  parameter int               NCH     = 6,
  parameter logic [1:0]       RST_RL  = 2'b11,
  parameter logic [ALG_W-1:0] RST_ALG = 3'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             commit,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_rl,
  input  logic [ALG_W-1:0] wr_alg,
  input  logic [CH_W-1:0]  rd_ch,
`ifdef JT12_ACC_SEQ_PCM_EN
  input  logic             pcm_req,
  output logic             pcm_cur,
`endif
  output logic             wr_ready,
  output logic [1:0]       rd_rl,
  output logic [ALG_W-1:0] rd_alg
);

  logic [1:0]       shadow_rl  [NCH];
  logic [ALG_W-1:0] shadow_alg [NCH];
  logic             pend_vld;
  logic [CH_W-1:0]  pend_ch;
  logic [1:0]       pend_rl;
  logic [ALG_W-1:0] pend_alg;

  assign wr_ready = !pend_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_ch  <= '0;
      pend_rl  <= RST_RL;
      pend_alg <= RST_ALG;
      for (int i = 0; i < NCH; i++) begin
        shadow_rl[i]  <= RST_RL;
        shadow_alg[i] <= RST_ALG;
      end
    end else if (clk_en) begin
      // Out-of-range channels match no entry, so they drain without touching the file.
      if (commit && pend_vld) begin
        for (int i = 0; i < NCH; i++) begin
          if (pend_ch == CH_W'(i)) begin
            shadow_rl[i]  <= pend_rl;
            shadow_alg[i] <= pend_alg;
          end
        end
      end
      if (wr_en && (!pend_vld || commit)) begin
        pend_vld <= 1'b1;
        pend_ch  <= wr_ch;
        pend_rl  <= wr_rl;
        pend_alg <= wr_alg;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef JT12_ACC_SEQ_PCM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcm_cur <= 1'b0;
    else if (clk_en && commit)
      pcm_cur <= pcm_req;
  end
`endif

  always_comb begin
    rd_rl  = RST_RL;
    rd_alg = RST_ALG;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_rl  = shadow_rl[i];
        rd_alg = shadow_alg[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jt12_acc_seq.sv
// jt12_acc_seq: 24-slot operator sequencer and rl/alg shadowing for the JT12 output accumulator.
// Optional macro JT12_ACC_SEQ_PCM_EN adds pcm_req and drives pcm_en.
`default_nettype none

module jt12_acc_seq
  import jt12_acc_seq_pkg::*;
#(
  parameter int               NCH     = 6,
  parameter logic [1:0]       RST_RL  = 2'b11,
  parameter logic [ALG_W-1:0] RST_ALG = 3'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             run,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_rl,
  input  logic [ALG_W-1:0] wr_alg,
`ifdef JT12_ACC_SEQ_PCM_EN
  input  logic             pcm_req,
`endif
  output logic             wr_ready,
  output logic             zero,
  output logic             s1_enters,
  output logic             s2_enters,
  output logic             s3_enters,
  output logic             s4_enters,
  output logic             ch6op,
  output logic [1:0]       rl,
  output logic [ALG_W-1:0] alg,
  output logic [CH_W-1:0]  cur_ch,
  output logic             sample_vld,
  output logic             pcm_en
);

  localparam int                NSLOT     = 4 * NCH;
  localparam int                SLOT_W    = $clog2(NSLOT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic              sample_nxt;
  logic              wrap;
  logic              active_nxt;
  logic [1:0]        grp_nxt;
  logic [CH_W-1:0]   ch_nxt;
  logic [3:0]        enters;
  logic              commit;

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    sample_nxt = 1'b0;
    wrap       = 1'b0;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_SYNC;
      ST_SYNC, ST_RUN: begin
        if (slot == LAST_SLOT) begin
          // run is only looked at here, so a round is never cut short.
          wrap       = 1'b1;
          slot_nxt   = '0;
          state_nxt  = run ? ST_RUN : ST_IDLE;
          sample_nxt = run;
        end else begin
          slot_nxt = slot + SLOT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    grp_nxt    = 2'(slot_nxt / SLOT_W'(NCH));
    ch_nxt     = CH_W'(slot_nxt % SLOT_W'(NCH));
    active_nxt = (state_nxt != ST_IDLE);
  end

  assign commit = clk_en && (wrap || (state == ST_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      slot       <= '0;
      sample_vld <= 1'b0;
      zero       <= 1'b0;
      enters     <= 4'b0;
      ch6op      <= 1'b0;
      cur_ch     <= '0;
    end else if (clk_en) begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      sample_vld <= sample_nxt;
      zero       <= active_nxt && (slot_nxt == '0);
      enters     <= active_nxt ? group_enters(grp_nxt) : 4'b0;
      ch6op      <= active_nxt && (ch_nxt == CH_W'(NCH - 1));
      cur_ch     <= ch_nxt;
    end
  end

  assign {s4_enters, s3_enters, s2_enters, s1_enters} = enters;

`ifdef JT12_ACC_SEQ_PCM_EN
  logic pcm_cur;
  assign pcm_en = pcm_cur && (state != ST_IDLE);
`else
  assign pcm_en = 1'b0;
`endif

  jt12_acc_seq_cfg #(
    .NCH     (NCH),
    .RST_RL  (RST_RL),
    .RST_ALG (RST_ALG)
  ) u_cfg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .commit   (commit),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_rl    (wr_rl),
    .wr_alg   (wr_alg),
    .rd_ch    (cur_ch),
`ifdef JT12_ACC_SEQ_PCM_EN
    .pcm_req  (pcm_req),
    .pcm_cur  (pcm_cur),
`endif
    .wr_ready (wr_ready),
    .rd_rl    (rl),
    .rd_alg   (alg)
  );

endmodule

`default_nettype wire

// File: tb/tb_jt12_acc_seq.sv
// tb_jt12_acc_seq: scoreboard bench; a round-level reference model queues expected slot outputs, a monitor compares them.
`default_nettype none

module tb_jt12_acc_seq;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, run, wr_en, pcm_req;
  logic [2:0] wr_ch, wr_alg;
  logic [1:0] wr_rl;

  logic       wr_ready, zero, s1_enters, s2_enters, s3_enters, s4_enters, ch6op;
  logic [1:0] rl;
  logic [2:0] alg, cur_ch;
  logic       sample_vld, pcm_en;

  always #5 clk = ~clk;

  jt12_acc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .run        (run),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_rl      (wr_rl),
    .wr_alg     (wr_alg),
`ifdef JT12_ACC_SEQ_PCM_EN
    .pcm_req    (pcm_req),
`endif
    .wr_ready   (wr_ready),
    .zero       (zero),
    .s1_enters  (s1_enters),
    .s2_enters  (s2_enters),
    .s3_enters  (s3_enters),
    .s4_enters  (s4_enters),
    .ch6op      (ch6op),
    .rl         (rl),
    .alg        (alg),
    .cur_ch     (cur_ch),
    .sample_vld (sample_vld),
    .pcm_en     (pcm_en)
  );

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  // Reference model: mode 0 idle, 1 first (discarded) round, 2 producing samples.
  int m_mode, m_slot;
  int m_rl[6], m_alg[6];
  bit m_pend;
  int m_pch, m_prl, m_palg;
  bit m_sample, m_pcm;
  int op_of_group[4] = '{1, 3, 2, 4};

  function automatic void model_reset();
    m_mode = 0; m_slot = 0; m_pend = 0; m_sample = 0; m_pcm = 0;
    for (int i = 0; i < 6; i++) begin
      m_rl[i]  = 3;
      m_alg[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit at_end, do_commit, take;
    if (!clk_en) return;
    at_end    = (m_mode != 0) && (m_slot == 23);
    do_commit = (m_mode == 0) || at_end;
    take      = wr_en && (!m_pend || do_commit);
    if (do_commit) begin
      if (m_pend && m_pch < 6) begin
        m_rl[m_pch]  = m_prl;
        m_alg[m_pch] = m_palg;
      end
      m_pcm = pcm_req;
    end
    if (take) begin
      m_pend = 1; m_pch = int'(wr_ch); m_prl = int'(wr_rl); m_palg = int'(wr_alg);
    end else if (do_commit) begin
      m_pend = 0;
    end
    m_sample = 0;
    if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (at_end) begin
      m_slot   = 0;
      m_sample = run;
      m_mode   = run ? 2 : 0;
    end else begin
      m_slot++;
    end
  endfunction

  function automatic logic [16:0] model_out();
    bit act;
    int ch, op;
    bit pe;
    act = (m_mode != 0);
    ch  = m_slot % 6;
    op  = act ? op_of_group[m_slot / 6] : 0;
`ifdef JT12_ACC_SEQ_PCM_EN
    pe = m_pcm && act;
`else
    pe = 0;
`endif
    return {!m_pend, act && m_slot == 0, op == 1, op == 2, op == 3, op == 4,
            act && ch == 5, 2'(m_rl[ch]), 3'(m_alg[ch]), 3'(ch), m_sample, pe};
  endfunction

  // Monitor: one expected record per presented cycle, compared away from the edge.
  always @(negedge clk) begin
    logic [16:0] got, expv;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      got  = {wr_ready, zero, s1_enters, s2_enters, s3_enters, s4_enters, ch6op,
              rl, alg, cur_ch, sample_vld, pcm_en};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL slot_outputs t=%0t got=%05h exp=%05h (rdy,zero,s1..s4,ch6op,rl,alg,ch,vld,pcm)",
                 $time, got, expv);
      end
    end
  end

  task automatic step(input bit r, input bit ce, input bit we, input int ch, input int nrl, input int nalg);
    run = r; clk_en = ce; wr_en = we;
    wr_ch = 3'(ch); wr_rl = 2'(nrl); wr_alg = 3'(nalg);
    @(posedge clk);
    #1;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic goto_slot(input int s, input bit r);
    for (int k = 0; k < 100 && !(m_mode != 0 && m_slot == s); k++) step(r, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bit rr;
    rst_n = 1'b0; run = 0; clk_en = 0; wr_en = 0; wr_ch = 0; wr_rl = 0; wr_alg = 0; pcm_req = 0;
    model_reset();
    do_reset();
    repeat (3) step(0, 1, 0, 0, 0, 0);
    repeat (60) step(1, 1, 0, 0, 0, 0);

    // Write at slot 10, dropped collision, then a write on the commit edge.
    goto_slot(10, 1);
    step(1, 1, 1, 2, 1, 4);
    step(1, 1, 1, 3, 2, 5);
    goto_slot(23, 1);
    step(1, 1, 1, 4, 2, 6);
    repeat (50) step(1, 1, 0, 0, 0, 0);

    // Invalid channel.
    goto_slot(3, 1);
    step(1, 1, 1, 7, 0, 7);
    repeat (30) step(1, 1, 0, 0, 0, 0);

    // Stop mid-round, then a write committed while idle.
    goto_slot(7, 1);
    repeat (30) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 2);
    repeat (3) step(0, 1, 0, 0, 0, 0);

    // Async reset mid-round with a write pending.
    goto_slot(12, 1);
    pcm_req = 1'b1;
    step(1, 1, 1, 5, 1, 3);
    goto_slot(15, 1);
    do_reset();
    pcm_req = 1'b0;
    repeat (5) step(0, 1, 0, 0, 0, 0);

    // Randomised traffic with gated clk_en and occasional resets.
    rr = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) rr = !rr;
      if ($urandom_range(49) == 0) pcm_req = !pcm_req;
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        step(rr, $urandom_range(3) != 0, $urandom_range(4) == 0,
             int'($urandom_range(7)), int'($urandom_range(3)), int'($urandom_range(7)));
      end
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jt12_acc_seq.md
Name: jt12_acc_seq

Overview:
- Slot sequencer and per-channel configuration shadow for the JT12 output accumulator.
- Walks 24 operator slots per sample round: 4 operator groups in chip order S1,S3,S2,S4, with 6 channels inside each group.
- Per slot it drives zero, s1..s4_enters, ch6op, rl and alg to the accumulator. It also holds rl/alg register writes until a round boundary so that a sample never mixes old and new settings.

Parameters:
- NCH, 6: channels per operator group; slots per round = 4*NCH.
- RST_RL, 2'b11: rl reset value for every channel (both outputs on).
- RST_ALG, 3'd0: alg reset value for every channel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  slot advance enable; all state changes are qualified by it except reset
- run  in  1  level request to sequence slots
- wr_en  in  1  configuration write strobe
- wr_ch  in  3  target channel 0..NCH-1
- wr_rl  in  2  new rl value
- wr_alg  in  3  new alg value
- wr_ready  out  1  write buffer free
- zero  out  1  first slot of a round
- s1_enters, s2_enters, s3_enters, s4_enters  out  1 each  one-hot operator group flag
- ch6op  out  1  current channel is NCH-1
- rl  out  2  rl of current channel
- alg  out  3  alg of current channel
- cur_ch  out  3  current channel
- sample_vld  out  1  one clk_en pulse meaning the accumulator output is a complete sample
- pcm_en  out  1  PCM enable for the last channel (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state IDLE, slot=0.
  - All one-bit outputs low except wr_ready=1.
  - rl/alg outputs show channel 0 reset values.
  - The shadow file and the pending buffer are loaded with RST_RL/RST_ALG and cleared.
- slot counter:
  - 0..4*NCH-1; group = slot/NCH, cur_ch = slot%NCH.
  - Wraps 4*NCH-1 -> 0.
  - Advances only on clk_en while in SYNC or RUN.
- Per-slot outputs:
  - Registered and valid in the same cycle as slot. Latency 0 from slot, 1 clk_en from counter increment.
  - Group to enters flag: 0 -> s1, 1 -> s3, 2 -> s2, 3 -> s4.
  - zero = (slot==0). ch6op = (cur_ch==NCH-1).
- States:
  - IDLE: counter held at 0, enters flags/zero/ch6op low. On run=1 with clk_en, go to SYNC.
  - SYNC: first round after start. Its accumulated data is not a valid sample. On wrap to slot 0, go to RUN. sample_vld stays 0.
  - RUN: sample_vld pulses for one clk_en at every slot 0. If run=0, finish the current round; at the wrap go to IDLE with no sample_vld pulse on that wrap (counter stops at 0).
  - run=0 during SYNC: go to IDLE at the wrap.
  - run toggling mid-round is sampled only at the wrap.
- Write buffer:
  - wr_en with wr_ready=1: capture {ch,rl,alg}, wr_ready <= 0.
  - wr_en with wr_ready=0: ignored, no side effect.
  - wr_ch >= NCH: captured, then discarded at commit, no file change.
  - Commit: on the clk_en edge where slot wraps to 0, the pending entry is written to the shadow file and wr_ready <= 1. The new values are visible from slot 0 of the next round.
  - In IDLE the commit happens on the next clk_en.
  - wr_en on the same edge as a commit: the committed entry frees the buffer, and the new write is captured on that edge (buffer stays occupied).
- Mid-operation reset: everything returns to reset values immediately. No partial commit.

Optional Feature:
- Macro JT12_ACC_SEQ_PCM_EN.
- With the macro defined:
  - extra input pcm_req (1 bit), shadowed like rl/alg and committed only at the round wrap.
  - pcm_en = committed pcm_req, but only in RUN/SYNC.
- Without the macro: pcm_en is constant 0 and pcm_req does not exist.

Decomposition:
- Package jt12_acc_seq_pkg holds:
  - state encoding (IDLE=0, SYNC=1, RUN=2)
  - group-to-operator map constants
  - CH_W=3 and ALG_W=3
- One sub-module, jt12_acc_seq_cfg: shadow register file plus the pending buffer and commit logic.
- The slot FSM and counter stay in the top module.

Test Plan:
- Reset and start:
  - Stimulus: rst_n low then high, run=1, clk_en every cycle.
  - Required: zero at slot 0; first sample_vld at slot 0 of round 2 (clk_en 25 after leaving IDLE); enters order s1 x6, s3 x6, s2 x6, s4 x6; ch6op on slots 5,11,17,23.
- Write timing:
  - Stimulus: in RUN at slot 10, write ch=2, rl=2'b01, alg=3'd4.
  - Required: rl/alg for ch 2 unchanged through slot 23; rl=01 and alg=4 at slot 2 of the next round; wr_ready low from slot 10 until the wrap.
- Write collision:
  - Stimulus: second wr_en while wr_ready=0.
  - Required: the second write is dropped.
  - Stimulus: a write on the commit edge.
  - Required: it is captured and committed one round later.
- Stop mid-round:
  - Stimulus: drop run at slot 7.
  - Required: slots continue to 23, then state IDLE, slot=0, no sample_vld on that wrap, all enters flags low.
- Async reset mid-round:
  - Stimulus: pulse rst_n low at slot 15 with a write pending.
  - Required: all outputs at reset values immediately, wr_ready=1, shadow file back to RST_RL/RST_ALG.
- Invalid channel and PCM:
  - Stimulus: write with ch=7.
  - Required: no channel changes.
  - Stimulus (JT12_ACC_SEQ_PCM_EN defined): pcm_req=1 raised mid-round.
  - Required: pcm_en rises only at the next slot 0.
